// File: rtl/async_fifo.sv
// Dual-clock FIFO: Gray-coded pointers cross via two-flop synchronizers.
// Define AFIFO_ERR_EN to add the sticky ovf (WCLK) and udf (RCLK) error outputs.
module async_fifo #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 4
) (
    input  logic             RST,
    input  logic             WCLK,
    input  logic             RCLK,
    input  logic [WIDTH-1:0] din,
    input  logic             enq,
    input  logic             deq,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
`ifdef AFIFO_ERR_EN
    ,
    output logic             ovf,
    output logic             udf
`endif
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam int PW    = ADDR_BITS + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wbin_q, wbin_d, wgray_q, wgray_d;
    logic [PW-1:0] rgray_w1_q, rgray_w2_q;
    logic          full_q, full_d, wr_ok;

    logic [PW-1:0] rbin_q, rbin_d, rgray_q, rgray_d;
    logic [PW-1:0] wgray_r1_q, wgray_r2_q;
    logic          empty_q, empty_d, rd_ok;
    logic [WIDTH-1:0] dout_q;

    // Write domain: full compares against the read pointer with its top two Gray bits flipped.
    always_comb begin
        wr_ok   = enq && !full_q;
        wbin_d  = wbin_q + {{ADDR_BITS{1'b0}}, wr_ok};
        wgray_d = (wbin_d >> 1) ^ wbin_d;
        full_d  = (wgray_d == {~rgray_w2_q[PW-1:PW-2], rgray_w2_q[PW-3:0]});
    end

    always_ff @(posedge WCLK) begin
        if (RST) begin
            wbin_q     <= '0;
            wgray_q    <= '0;
            rgray_w1_q <= '0;
            rgray_w2_q <= '0;
            full_q     <= 1'b0;
        end else begin
            wbin_q     <= wbin_d;
            wgray_q    <= wgray_d;
            rgray_w1_q <= rgray_q;
            rgray_w2_q <= rgray_w1_q;
            full_q     <= full_d;
        end
    end

    always_ff @(posedge WCLK) begin
        if (wr_ok && !RST) begin
            mem_q[wbin_q[ADDR_BITS-1:0]] <= din;
        end
    end

    // Read domain: empty when the advanced read pointer catches the synchronized write pointer.
    always_comb begin
        rd_ok   = deq && !empty_q;
        rbin_d  = rbin_q + {{ADDR_BITS{1'b0}}, rd_ok};
        rgray_d = (rbin_d >> 1) ^ rbin_d;
        empty_d = (rgray_d == wgray_r2_q);
    end

    always_ff @(posedge RCLK) begin
        if (RST) begin
            rbin_q     <= '0;
            rgray_q    <= '0;
            wgray_r1_q <= '0;
            wgray_r2_q <= '0;
            empty_q    <= 1'b1;
            dout_q     <= '0;
        end else begin
            rbin_q     <= rbin_d;
            rgray_q    <= rgray_d;
            wgray_r1_q <= wgray_q;
            wgray_r2_q <= wgray_r1_q;
            empty_q    <= empty_d;
            if (rd_ok) begin
                dout_q <= mem_q[rbin_q[ADDR_BITS-1:0]];
            end
        end
    end

    assign dout  = dout_q;
    assign full  = full_q;
    assign empty = empty_q;

`ifdef AFIFO_ERR_EN
    logic ovf_q, udf_q;

    always_ff @(posedge WCLK) begin
        if (RST) begin
            ovf_q <= 1'b0;
        end else if (enq && full_q) begin
            ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge RCLK) begin
        if (RST) begin
            udf_q <= 1'b0;
        end else if (deq && empty_q) begin
            udf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`else
    // Without error flags, illegal requests are dropped by the wr_ok/rd_ok gating alone.
`endif

endmodule

// File: tb/tb_async_fifo.sv
// Self-checking bench for async_fifo: randomized traffic against a queue reference model.
// Build with AFIFO_ERR_EN defined to also check the sticky ovf/udf flags.
module tb_async_fifo;

    localparam int DEPTH = 16;

    logic        WCLK = 1'b0;
    logic        RCLK = 1'b0;
    logic        RST  = 1'b1;
    logic [31:0] din  = '0;
    logic        enq  = 1'b0;
    logic        deq  = 1'b0;
    logic [31:0] dout;
    logic        full;
    logic        empty;
`ifdef AFIFO_ERR_EN
    logic        ovf;
    logic        udf;
`endif

    async_fifo #(.WIDTH(32), .ADDR_BITS(4)) dut (
        .RST   (RST),
        .WCLK  (WCLK),
        .RCLK  (RCLK),
        .din   (din),
        .enq   (enq),
        .deq   (deq),
        .dout  (dout),
        .full  (full),
        .empty (empty)
`ifdef AFIFO_ERR_EN
        ,
        .ovf   (ovf),
        .udf   (udf)
`endif
    );

    always #10 WCLK = ~WCLK;

    initial begin
        #2;
        forever begin
            RCLK = 1'b1;
            #5;
            RCLK = 1'b0;
            #5;
        end
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_q [$];
    logic [31:0] last_dout = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One WCLK cycle of producer activity; the model records words the FIFO accepts.
    task automatic wr_step(input bit want, input logic [31:0] data, output bit took);
        @(negedge WCLK);
        if (model_q.size() >= DEPTH) chk("full_vs_model", full, 1);
        enq = want && !full;
        din = data;
        if (enq) chk("no_overfill", model_q.size() < DEPTH, 1);
        @(posedge WCLK);
        took = enq;
        if (took) model_q.push_back(data);
        #1 enq = 1'b0;
    endtask

    task automatic rd_step(input bit want, output bit took);
        logic [31:0] e;
        @(negedge RCLK);
        if (model_q.size() == 0) chk("empty_vs_model", empty, 1);
        deq = want && !empty;
        @(posedge RCLK);
        took = deq;
        #1 deq = 1'b0;
        if (took) begin
            if (model_q.size() == 0) begin
                chk("read_beyond_model", 1, 0);
            end else begin
                e = model_q.pop_front();
                chk("dout", dout, e);
                last_dout = e;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   took;
        int   cnt;
        int   wr_done, rd_done;
        logic [31:0] base;

        // Reset with writes attempted throughout.
        RST = 1'b1;
        enq = 1'b1;
        din = 32'hDEAD_BEEF;
        repeat (2) @(posedge WCLK);
        for (int i = 0; i < 17; i++) begin
            @(negedge WCLK);
            chk("reset_full", full, 0);
            chk("reset_empty", empty, 1);
            chk("reset_dout", dout, 0);
        end
        @(negedge WCLK);
        RST = 1'b0;
        enq = 1'b0;
        repeat (10) @(negedge RCLK);
        chk("no_store_in_reset", empty, 1);
`ifdef AFIFO_ERR_EN
        chk("ovf_after_reset", ovf, 0);
        chk("udf_after_reset", udf, 0);
`endif

        // Fill with a counting pattern and no reader.
        cnt = 0;
        for (int i = 0; i < 60 && cnt < DEPTH; i++) begin
            wr_step(1'b1, 32'(cnt), took);
            if (took) begin
                if (cnt == 0) fork begin #30; chk("empty_deassert", empty, 0); end join_none
                cnt++;
            end
        end
        chk("fill_count", cnt, DEPTH);
        @(negedge WCLK);
        chk("full_after_fill", full, 1);
        repeat (3) wr_step(1'b1, 32'hFFFF_FFFF, took);
        chk("full_holds", full, 1);

        // Drain back out in order.
        cnt = 0;
        for (int i = 0; i < 200 && cnt < DEPTH; i++) begin
            rd_step(1'b1, took);
            if (took) begin
                if (cnt == 0) fork begin #61; chk("full_deassert", full, 0); end join_none
                cnt++;
                if (cnt == DEPTH) chk("empty_on_last", empty, 1);
            end
        end
        chk("drain_count", cnt, DEPTH);
        chk("drain_last_word", dout, 15);
        repeat (8) @(posedge WCLK);

        // Streaming: random producer gaps against a bursty 4-in-10 reader.
        base = $urandom;
        wr_done = 0;
        rd_done = 0;
        fork
            begin
                bit t;
                for (int i = 0; i < 30000 && wr_done < 2000; i++) begin
                    wr_step($urandom_range(0, 9) < 8, base + 32'(wr_done), t);
                    if (t) wr_done++;
                end
            end
            begin
                bit t;
                for (int i = 0; i < 30000 && rd_done < 2000; i++) begin
                    rd_step((i % 10) < 4, t);
                    if (t) rd_done++;
                end
            end
        join
        chk("stream_written", wr_done, 2000);
        chk("stream_read", rd_done, 2000);
        chk("stream_last", last_dout, base + 32'd1999);
        chk("stream_drained", model_q.size(), 0);
        repeat (8) @(posedge WCLK);

        // Overrun: fill with random words, then hammer enq while full.
        cnt = 0;
        for (int i = 0; i < 80 && cnt < DEPTH; i++) begin
            wr_step(1'b1, $urandom, took);
            if (took) cnt++;
        end
        chk("ovr_fill_count", cnt, DEPTH);
`ifdef AFIFO_ERR_EN
        chk("ovf_clear_before", ovf, 0);
`endif
        for (int i = 0; i < 20; i++) begin
            @(negedge WCLK);
            enq = 1'b1;
            din = $urandom;
            @(posedge WCLK);
            #1 chk("full_hold_ovr", full, 1);
        end
        enq = 1'b0;
`ifdef AFIFO_ERR_EN
        chk("ovf_set", ovf, 1);
`endif
        cnt = 0;
        for (int i = 0; i < 200 && cnt < DEPTH; i++) begin
            rd_step(1'b1, took);
            if (took) cnt++;
        end
        chk("ovr_drain_count", cnt, DEPTH);

        // Underrun: hammer deq while empty.
        for (int i = 0; i < 20; i++) begin
            @(negedge RCLK);
            deq = 1'b1;
            @(posedge RCLK);
            #1 begin
                chk("dout_hold_udr", dout, last_dout);
                chk("empty_hold_udr", empty, 1);
            end
        end
        deq = 1'b0;
`ifdef AFIFO_ERR_EN
        chk("udf_set", udf, 1);
        chk("ovf_sticky", ovf, 1);
`endif

        // Mid-run reset with 7 words buffered.
        cnt = 0;
        for (int i = 0; i < 40 && cnt < 7; i++) begin
            wr_step(1'b1, $urandom, took);
            if (took) cnt++;
        end
        repeat (10) @(negedge WCLK);
        chk("midrun_not_empty", empty, 0);
        RST = 1'b1;
        model_q.delete();
        repeat (2) @(negedge WCLK);
        chk("midrun_rst_empty", empty, 1);
        chk("midrun_rst_full", full, 0);
        chk("midrun_rst_dout", dout, 0);
`ifdef AFIFO_ERR_EN
        chk("midrun_rst_ovf", ovf, 0);
        chk("midrun_rst_udf", udf, 0);
`endif
        repeat (6) @(negedge WCLK);
        RST = 1'b0;
        repeat (5) @(negedge WCLK);
        chk("midrun_discarded", empty, 1);
        wr_step(1'b1, 32'hA5A5_A5A5, took);
        chk("midrun_write_taken", took, 1);
        cnt = 0;
        for (int i = 0; i < 50 && cnt < 1; i++) begin
            rd_step(1'b1, took);
            if (took) cnt++;
        end
        chk("midrun_read_count", cnt, 1);
        chk("first_after_reset", dout, 32'hA5A5_A5A5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
